irq_pend_ctrl: RTL

Request-capture stage upstream of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines, latches them as sticky pending bits and applies a per-line enable mask. It drives the masked vector to the encoder's `d_in`, then clears the serviced bit when the consumer acknowledges the encoder's index. Overrun bits are sticky and flag requests lost while their line was already pending.

---
 rtl/irq_pend_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/irq_pend_ctrl.sv
// irq_pend_ctrl -- request capture ahead of the 8-to-3 priority encoder.
//
// Each of the eight request lines is synchronised, turned into an event
// (rising edge or level), and latched as a sticky pending bit. The masked
// pending vector is registered onto d_out for the encoder. An ack naming
// the encoder's index clears that pending bit. Overrun flags record events
// lost because their line was already pending.
//
// Build option:
//   IRQ_EDGE_EN  defined   : edge-triggered events, overrun detection active
//                undefined : level-triggered events, ovf tied to 0, ovf_clr ignored
//
// Parameters:
//   SYNC_STAGES  input synchroniser depth, 1..3 (default 2)
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req_in     [7:0] asynchronous request lines (bit 7 highest priority)
//   mask_in    [7:0] per-line enable, 1 = visible to the encoder
//   d_out      [7:0] registered masked pending vector (encoder d_in)
//   irq_valid  registered OR of d_out
//   a_in       [2:0] index from the encoder's a_out
//   ack        acknowledge for index a_in
//   pend_out   [7:0] raw pending register, unmasked
//   ovf        [7:0] sticky overrun flags
//   ovf_clr    clears all ovf bits

// One request line: synchroniser, event detect, pending bit, overrun flag.
module irq_pend_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  input  logic ovf_clr,
  output logic pend,
  output logic pend_n,
  output logic ovf
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= req;
      for (int j = 1; j < SYNC_STAGES; j++) sync[j] <= sync[j-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef IRQ_EDGE_EN
  logic s_d;

  // s_d resets low, so a line held high across reset release gives one event.
  always_ff @(posedge clk) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign evt = s & ~s_d;

  // A fresh overrun takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                   ovf <= 1'b0;
    else if (evt & pend & ~clr)   ovf <= 1'b1;
    else if (ovf_clr)             ovf <= 1'b0;
  end
`else
  logic ovf_clr_unused;

  assign evt            = s;
  assign ovf            = 1'b0;
  assign ovf_clr_unused = ovf_clr;
`endif

  // Set beats clear when both land on the same edge.
  assign pend_n = evt | (pend & ~clr);

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= pend_n;
  end

endmodule

module irq_pend_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic [7:0] mask_in,
  output logic [7:0] d_out,
  output logic       irq_valid,
  input  logic [2:0] a_in,
  input  logic       ack,
  output logic [7:0] pend_out,
  output logic [7:0] ovf,
  input  logic       ovf_clr
);

  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0] clr;
  logic [NUM_LANES-1:0] pend;
  logic [NUM_LANES-1:0] pend_n;
  logic [NUM_LANES-1:0] masked_n;

  // Only a bit the encoder can actually be presenting may be cleared; acks
  // naming an idle or hidden line fall through harmlessly.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign clr[i] = ack & irq_valid & d_out[i] & (a_in == 3'(i));

    irq_pend_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_in[i]),
      .clr     (clr[i]),
      .ovf_clr (ovf_clr),
      .pend    (pend[i]),
      .pend_n  (pend_n[i]),
      .ovf     (ovf[i])
    );
  end

  // Built from next-state pending so d_out and pend_out move on the same
  // edge and d_out never shows an already-serviced bit.
  assign masked_n = pend_n & mask_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_out     <= '0;
      irq_valid <= 1'b0;
    end else begin
      d_out     <= masked_n;
      irq_valid <= |masked_n;
    end
  end

  assign pend_out = pend;

endmodule
